sd_drive_scheduler: RTL and testbench
=====================================

SD_DRIVE_SCHEDULER -- requirements
Module: sd_drive_scheduler

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 50000000, which sets the number of clk_sys cycles to wait for sd_ack before aborting a request.
REQ-002 Port clk_sys, input, width 1: the single clock; all logic is rising-edge.
REQ-003 Port reset, input, width 1: asynchronous, active-high reset.
REQ-004 Port req_rd, input, width 3: one-cycle block-read strobe per drive (bit0 D1, bit1 D2, bit2 cart).
REQ-005 Port req_wr, input, width 3: one-cycle block-write strobe per drive.
REQ-006 Port req_lba, input, width 96: sector number per drive; drive i uses bits [32i+31:32i].
REQ-007 Port sd_lba, output, width 32: sector number presented to hps_io.
REQ-008 Port sd_rd, output, width 3: read request to hps_io, one-hot.
REQ-009 Port sd_wr, output, width 3: write request to hps_io, one-hot.
REQ-010 Port sd_ack, input, width 1: transfer-in-progress acknowledge from hps_io.
REQ-011 Port done, output, width 3: one-cycle completion pulse per drive.
REQ-012 Port err, output, width 3: one-cycle timeout pulse per drive.
REQ-013 Port busy, output, width 1: high whenever the state is not IDLE.
REQ-014 Port pending, output, width 3: per-drive request-outstanding flags.

Function
REQ-015 Capture: a strobe on req_rd[i] or req_wr[i] at edge N SHALL set pending[i], latch the dir[i] bit (1 = write) and latch lba[i] from req_lba, all visible after edge N.
REQ-016 If req_rd[i] and req_wr[i] are asserted in the same cycle, the read SHALL win.
REQ-017 A strobe for a drive whose pending[i] is already set SHALL be ignored; the latched lba and dir SHALL be left unchanged.
REQ-018 The FSM SHALL have four states: IDLE, WAIT_ACK, XFER and DONE.
REQ-019 In IDLE with any pending bit set, the FSM SHALL grant drive g, chosen round-robin starting at last_grant+1 mod 3.
- On that same edge it SHALL load sd_lba=lba[g], set sd_rd[g]=~dir[g] and sd_wr[g]=dir[g], clear the wait counter, and go to WAIT_ACK.
- sd_rd/sd_wr therefore assert 2 cycles after the strobe when the block is idle.
REQ-020 In WAIT_ACK, sd_ack sampled high SHALL clear sd_rd and sd_wr and move the FSM to XFER.
- Otherwise the wait counter SHALL increment.
- When the counter reaches TIMEOUT-1, the FSM SHALL clear sd_rd/sd_wr, pulse err[g] for one cycle, clear pending[g], set last_grant=g and return to IDLE.
REQ-021 In XFER, sd_ack sampled low SHALL move the FSM to DONE; there is no timeout in XFER.
REQ-022 In DONE, the block SHALL pulse done[g] for exactly one cycle, clear pending[g], set last_grant=g, and go to IDLE on the next edge.
REQ-023 A new strobe for the granted drive SHALL be accepted on the same edge that clears pending[g]; capture takes priority, so pending[g] stays set.
REQ-024 Strobes for non-granted drives SHALL be captured in any state.
REQ-025 sd_lba SHALL stay stable from the grant until the FSM returns to IDLE.
REQ-026 At most one bit of sd_rd|sd_wr SHALL be set at any time.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 The wait counter SHALL be 26 bits wide and saturate; it SHALL never wrap.

Reset
REQ-029 While reset is high, the block SHALL hold state=IDLE, last_grant=2 (so drive 0 has first priority), and pending, dir, lba, sd_lba, sd_rd, sd_wr, done, err, busy and the wait counter all 0.
REQ-030 Reset asserted mid-transfer SHALL drop the request immediately, with no done or err pulse.

Verification
REQ-031 Single read: req_rd=3'b001 with lba0=0x10 -> 2 cycles later sd_rd=001 and sd_lba=0x10; sd_ack high for 512 cycles then low -> done=001 for one cycle and pending=000.
REQ-032 Contention: req_rd=001, req_wr=010 and req_rd=100 in the same cycle -> services in order D1 (read), D2 (write), cart (read), each with one done pulse and sd_wr=010 only for D2.
REQ-033 Same-drive rd+wr: req_rd=010 and req_wr=010 together -> sd_rd=010 and sd_wr=000.
REQ-034 Timeout with TIMEOUT=16: req_wr=001 and sd_ack held low -> sd_wr clears and err=001 pulses 16 cycles after sd_wr asserts; no done pulse.
REQ-035 Duplicate and reset: a second req_rd=001 with a different lba while pending -> original lba issued; then reset asserted during XFER -> all outputs 0 immediately, and no done pulse after reset is released.

Source files
------------

// File: rtl/sd_drive_scheduler.sv
// Round-robin arbiter of block read/write requests from three drives onto one hps_io SD port.
// Grant 2 cycles after strobe; strobes while a drive is pending are dropped; sd_ack paces the transfer.
module sd_drive_scheduler #(
  parameter int TIMEOUT = 50000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [2:0]  req_rd,
  input  logic [2:0]  req_wr,
  input  logic [95:0] req_lba,
  output logic [31:0] sd_lba,
  output logic [2:0]  sd_rd,
  output logic [2:0]  sd_wr,
  input  logic        sd_ack,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic        busy,
  output logic [2:0]  pending
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, XFER, DONE} state_t;

  localparam logic [25:0] WAIT_LAST = 26'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       last_grant;
  logic [1:0]       grant;
  logic [1:0]       next_grant;
  logic [2:0]       grant_mask;
  logic [2:0]       next_mask;
  logic [2:0]       dir;
  logic [2:0][31:0] lba;
  logic [25:0]      wait_cnt;
  logic [2:0]       strobe;
  logic [2:0]       clr;
  logic             timed_out;

  assign strobe     = req_rd | req_wr;
  assign busy       = (state != IDLE);
  assign grant_mask = 3'b001 << grant;
  assign next_mask  = 3'b001 << next_grant;
  assign timed_out  = (state == WAIT_ACK) && !sd_ack && (wait_cnt == WAIT_LAST);
  assign clr        = ((state == DONE) || timed_out) ? grant_mask : 3'b000;

  // Search order starts one past the drive served last.
  always_comb begin
    next_grant = 2'd0;
    case (last_grant)
      2'd0:    next_grant = pending[1] ? 2'd1 : (pending[2] ? 2'd2 : 2'd0);
      2'd1:    next_grant = pending[2] ? 2'd2 : (pending[0] ? 2'd0 : 2'd1);
      default: next_grant = pending[0] ? 2'd0 : (pending[1] ? 2'd1 : 2'd2);
    endcase
  end

  // A strobe landing on the edge that retires the drive is kept, so pending stays set.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pending <= 3'b000;
      dir     <= 3'b000;
      lba     <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (strobe[i] && (!pending[i] || clr[i])) begin
          pending[i] <= 1'b1;
          dir[i]     <= ~req_rd[i];
          lba[i]     <= req_lba[32*i +: 32];
        end else if (clr[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 2'd2;
      grant      <= 2'd0;
      sd_lba     <= 32'd0;
      sd_rd      <= 3'b000;
      sd_wr      <= 3'b000;
      done       <= 3'b000;
      err        <= 3'b000;
      wait_cnt   <= 26'd0;
    end else begin
      done <= 3'b000;
      err  <= 3'b000;
      case (state)
        IDLE: begin
          if (|pending) begin
            grant    <= next_grant;
            sd_lba   <= lba[next_grant];
            sd_rd    <= dir[next_grant] ? 3'b000 : next_mask;
            sd_wr    <= dir[next_grant] ? next_mask : 3'b000;
            wait_cnt <= 26'd0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sd_ack) begin
            sd_rd <= 3'b000;
            sd_wr <= 3'b000;
            state <= XFER;
          end else if (timed_out) begin
            sd_rd      <= 3'b000;
            sd_wr      <= 3'b000;
            err        <= grant_mask;
            last_grant <= grant;
            state      <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 26'd1;
          end
        end
        XFER: begin
          if (!sd_ack) state <= DONE;
        end
        DONE: begin
          done       <= grant_mask;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_drive_scheduler.sv
// Bench for sd_drive_scheduler: request-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sd_drive_scheduler;
  localparam int TO = 16;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [2:0]  req_rd  = 3'b000;
  logic [2:0]  req_wr  = 3'b000;
  logic [95:0] req_lba = '0;
  logic        sd_ack  = 1'b0;
  logic [31:0] sd_lba;
  logic [2:0]  sd_rd, sd_wr, done, err, pending;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  sd_drive_scheduler #(.TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
    .req_lba(req_lba), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .done(done), .err(err), .busy(busy), .pending(pending)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: which drives hold a request, which one is being served,
  // and how far that service has progressed.
  logic [2:0]  m_pend, m_dir, m_rd, m_wr, m_done, m_err;
  logic [31:0] m_lba [3];
  logic [31:0] m_sdlba;
  int          m_last, m_drv, m_waited;
  bit          m_serving, m_acked, m_finishing;

  always @(posedge clk_sys) begin
    logic [2:0] retire;
    int g;
    if (reset) begin
      m_pend = 0; m_dir = 0; m_rd = 0; m_wr = 0; m_done = 0; m_err = 0;
      for (int i = 0; i < 3; i++) m_lba[i] = 0;
      m_sdlba = 0; m_last = 2; m_drv = 0; m_waited = 0;
      m_serving = 0; m_acked = 0; m_finishing = 0;
    end else begin
      retire = 0; m_done = 0; m_err = 0;
      if (!m_serving) begin
        if (m_pend != 0) begin
          g = -1;
          for (int k = 1; k <= 3; k++)
            if (g < 0 && m_pend[(m_last + k) % 3]) g = (m_last + k) % 3;
          m_drv = g; m_serving = 1; m_acked = 0; m_finishing = 0; m_waited = 0;
          m_sdlba = m_lba[g];
          m_rd = m_dir[g] ? 3'b000 : 3'(1 << g);
          m_wr = m_dir[g] ? 3'(1 << g) : 3'b000;
        end
      end else if (m_finishing) begin
        m_done = 3'(1 << m_drv); retire = m_done; m_last = m_drv; m_serving = 0;
      end else if (!m_acked) begin
        if (sd_ack) begin
          m_acked = 1; m_rd = 0; m_wr = 0;
        end else if (m_waited == TO - 1) begin
          m_err = 3'(1 << m_drv); retire = m_err; m_last = m_drv; m_serving = 0;
          m_rd = 0; m_wr = 0;
        end else begin
          m_waited++;
        end
      end else if (!sd_ack) begin
        m_finishing = 1;
      end
      for (int i = 0; i < 3; i++) begin
        if ((req_rd[i] || req_wr[i]) && (!m_pend[i] || retire[i])) begin
          m_pend[i] = 1; m_dir[i] = !req_rd[i]; m_lba[i] = req_lba[32*i +: 32];
        end else if (retire[i]) begin
          m_pend[i] = 0;
        end
      end
    end
  end

  always @(posedge clk_sys) begin
    #2;
    chk("cyc_sd_rd", sd_rd, m_rd);
    chk("cyc_sd_wr", sd_wr, m_wr);
    chk("cyc_sd_lba", sd_lba, m_sdlba);
    chk("cyc_done", done, m_done);
    chk("cyc_err", err, m_err);
    chk("cyc_busy", busy, m_serving);
    chk("cyc_pending", pending, m_pend);
    checks++;
    if (((sd_rd | sd_wr) & ((sd_rd | sd_wr) - 3'd1)) != 0) begin
      failures++;
      $display("FAIL cyc_onehot at %0t: got %0b expected at most one bit", $time, sd_rd | sd_wr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic strobe(input logic [2:0] rd, input logic [2:0] wr, input logic [95:0] l);
    @(negedge clk_sys);
    req_rd = rd; req_wr = wr; req_lba = l;
    @(negedge clk_sys);
    req_rd = 0; req_wr = 0;
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while ((sd_rd | sd_wr) == 0 && n < 40) begin
      tick(1);
      n++;
    end
    chk(name, ((sd_rd | sd_wr) != 0), 1);
  endtask

  task automatic ack_burst(input int hold);
    sd_ack = 1'b1;
    tick(hold);
    sd_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  logic [2:0]  exp_rd  [3] = '{3'b001, 3'b000, 3'b100};
  logic [2:0]  exp_wr  [3] = '{3'b000, 3'b010, 3'b000};
  logic [31:0] exp_lba [3] = '{32'h100, 32'h200, 32'h300};

  initial begin
    int  cnt;
    bit  done_seen;

    tick(3);
    chk("rst_pending", pending, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sd_rd", sd_rd | sd_wr, 3'b000);
    chk("rst_sd_lba", sd_lba, 32'h0);
    reset = 1'b0;
    tick(2);

    // Single read of D1.
    strobe(3'b001, 3'b000, {64'h0, 32'h10});
    chk("rd_pending_latched", pending, 3'b001);
    chk("rd_not_yet_issued", sd_rd, 3'b000);
    tick(1);
    chk("rd_sd_rd", sd_rd, 3'b001);
    chk("rd_sd_lba", sd_lba, 32'h10);
    chk("rd_model_lba", m_sdlba, 32'h10);
    sd_ack = 1'b1;
    tick(1);
    chk("rd_req_dropped_on_ack", sd_rd, 3'b000);
    tick(511);
    sd_ack = 1'b0;
    tick(1);
    chk("rd_no_early_done", done, 3'b000);
    tick(1);
    chk("rd_done", done, 3'b001);
    chk("rd_pending_clear", pending, 3'b000);
    tick(1);
    chk("rd_done_one_cycle", done, 3'b000);

    // Three-way contention after reset: D1, D2, cart.
    pulse_reset();
    strobe(3'b101, 3'b010, {32'h300, 32'h200, 32'h100});
    for (int s = 0; s < 3; s++) begin
      wait_issue("cont_issue");
      chk("cont_sd_rd", sd_rd, exp_rd[s]);
      chk("cont_sd_wr", sd_wr, exp_wr[s]);
      chk("cont_sd_lba", sd_lba, exp_lba[s]);
      ack_burst(4);
      tick(2);
      chk("cont_done", done, exp_rd[s] | exp_wr[s]);
    end

    // Read and write on the same drive: read wins.
    strobe(3'b010, 3'b010, {32'h0, 32'h55, 32'h0});
    tick(1);
    chk("rdwr_sd_rd", sd_rd, 3'b010);
    chk("rdwr_sd_wr", sd_wr, 3'b000);
    chk("rdwr_lba", sd_lba, 32'h55);
    ack_burst(3);
    tick(2);
    chk("rdwr_done", done, 3'b010);

    // New strobe for the drive on the edge that retires it.
    strobe(3'b001, 3'b000, {64'h0, 32'h77});
    wait_issue("restrobe_issue");
    ack_burst(3);
    tick(1);
    req_wr = 3'b001; req_lba = {64'h0, 32'h88};
    tick(1);
    req_wr = 3'b000;
    chk("restrobe_done", done, 3'b001);
    chk("restrobe_pending_kept", pending, 3'b001);
    tick(1);
    chk("restrobe_sd_wr", sd_wr, 3'b001);
    chk("restrobe_lba", sd_lba, 32'h88);
    ack_burst(2);
    tick(3);

    // Write timeout with sd_ack never arriving.
    strobe(3'b000, 3'b001, {64'h0, 32'h9});
    wait_issue("to_issue");
    chk("to_sd_wr", sd_wr, 3'b001);
    cnt = 0; done_seen = 0;
    while (err == 0 && cnt < 40) begin
      tick(1);
      cnt++;
      if (done != 0) done_seen = 1;
    end
    chk("to_cycles", cnt, TO);
    chk("to_err", err, 3'b001);
    chk("to_sd_wr_cleared", sd_wr, 3'b000);
    chk("to_pending_clear", pending, 3'b000);
    chk("to_no_done", done_seen, 0);
    tick(3);

    // Duplicate strobe ignored, then reset mid-transfer.
    strobe(3'b001, 3'b000, {64'h0, 32'hA1});
    strobe(3'b001, 3'b000, {64'h0, 32'hB2});
    wait_issue("dup_issue");
    chk("dup_lba", sd_lba, 32'hA1);
    sd_ack = 1'b1;
    tick(3);
    chk("dup_in_xfer", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs", {sd_rd, sd_wr, done, err, pending, 3'b000, busy}, 0);
    chk("rst_mid_lba", sd_lba, 32'h0);
    sd_ack = 1'b0;
    tick(2);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (done != 0 || err != 0) done_seen = 1;
    end
    chk("rst_no_done_after", done_seen, 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
